// File: rtl/mod_down_timer.sv
// -----------------------------------------------------------------------------
// mod_down_timer
//
// Programmable down-counting timer. A start pulse loads load_value and the
// block then counts enabled cycles down to zero. On expiry it emits a
// one-cycle done pulse. If auto_reload is high at expiry it reloads and keeps
// running. enable low pauses the count and stop aborts it.
//
// Parameters
//   n            counter width in bits (2..32)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        load load_value and begin counting (sampled on clk rise)
//   stop         abort the current count; has priority over start
//   enable       count-advance qualifier; low pauses the count
//   auto_reload  at expiry, reload load_value and stay running
//   load_value   period in enabled cycles (0 = expire immediately)
//   count        remaining count (registered)
//   busy         high while running (registered)
//   done         one-cycle expiry pulse (registered)
// -----------------------------------------------------------------------------
module mod_down_timer #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stop,
    input  logic         enable,
    input  logic         auto_reload,
    input  logic [n-1:0] load_value,
    output logic [n-1:0] count,
    output logic         busy,
    output logic         done
);

    localparam logic [0:0]   ST_IDLE  = 1'b0;
    localparam logic [0:0]   ST_RUN   = 1'b1;
    localparam logic [n-1:0] CNT_ZERO = {n{1'b0}};
    localparam logic [n-1:0] CNT_ONE  = {{(n-1){1'b0}}, 1'b1};

    logic [0:0]   state_r;
    logic [0:0]   state_s;
    logic [n-1:0] count_r;
    logic [n-1:0] count_s;
    logic         done_r;
    logic         done_s;
    logic         busy_r;
    logic         load_zero_s;

    assign load_zero_s = (load_value == CNT_ZERO);

    // Next-state / next-count decode: stop beats start, start beats counting.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    count_s = CNT_ZERO;
                end else if (start) begin
                    if (load_zero_s) begin
                        // Zero-length timer expires on the sampling edge.
                        done_s  = 1'b1;
                        count_s = CNT_ZERO;
                    end else begin
                        count_s = load_value;
                        state_s = ST_RUN;
                    end
                end else begin
                    count_s = count_r;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    count_s = CNT_ZERO;
                    state_s = ST_IDLE;
                end else if (start) begin
                    // Restart discards the interrupted count without a done.
                    if (load_zero_s) begin
                        done_s  = 1'b1;
                        count_s = CNT_ZERO;
                        state_s = ST_IDLE;
                    end else begin
                        count_s = load_value;
                    end
                end else if (enable) begin
                    if (count_r > CNT_ONE) begin
                        count_s = count_r - CNT_ONE;
                    end else begin
                        // count 1 is the last enabled cycle; a stray 0 is
                        // treated the same so RUN can never stall.
                        done_s = 1'b1;
                        if (auto_reload && !load_zero_s) begin
                            count_s = load_value;
                        end else begin
                            count_s = CNT_ZERO;
                            state_s = ST_IDLE;
                        end
                    end
                end else begin
                    count_s = count_r;
                end
            end
            default: begin
                count_s = CNT_ZERO;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, count and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            done_r  <= done_s;
            busy_r  <= (state_s == ST_RUN);
        end
    end

    assign count = count_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_mod_down_timer.sv
// -----------------------------------------------------------------------------
// tb_mod_down_timer
//
// Directed bench for mod_down_timer (n=4). A behavioural model tracks the
// remaining enabled cycles and the running flag; a compare process checks
// count/busy/done against it on every falling edge. Directed sequences add
// hand-computed literal expectations for the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_mod_down_timer;

    localparam int N_W = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           enable = 1'b0;
    logic           auto_reload = 1'b0;
    logic [N_W-1:0] load_value = 4'd0;
    logic [N_W-1:0] count;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    mod_down_timer #(.n(N_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .enable     (enable),
        .auto_reload(auto_reload),
        .load_value (load_value),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Model: remaining enabled cycles, running flag, expiry pulse.
    typedef struct packed {
        logic        run;
        logic        dn;
        logic [31:0] left;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(input model_t cur, input bit st, input bit sp,
                                          input bit en, input bit ar, input int lv);
        model_t nx;
        nx = cur;
        nx.dn = 1'b0;
        if (sp) begin
            nx.run  = 1'b0;
            nx.left = 0;
        end else if (st) begin
            nx.left = lv;
            nx.run  = (lv != 0);
            nx.dn   = (lv == 0);
        end else if (cur.run && en) begin
            if (cur.left - 1 == 0) begin
                nx.dn   = 1'b1;
                nx.run  = ar && (lv != 0);
                nx.left = nx.run ? lv : 0;
            end else begin
                nx.left = cur.left - 1;
            end
        end
        return nx;
    endfunction

    // Advance the model on every sampled edge; reset clears it at once.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            m <= '0;
        else
            m <= model_next(m, start, stop, enable, auto_reload, int'(load_value));
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_count", int'(count), int'(m.left));
            check("model_busy", int'(busy), int'(m.run));
            check("model_done", int'(done), int'(m.dn));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] seq [6];
    int         done_at;
    logic [11:0] done_mask;
    bit         busy_all;

    initial begin
        seq = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

        // Reset state
        #1 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // Reset mid-count
        enable = 1'b1;
        load_value = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midrst_load", int'(count), 9);
        tick(); tick(); tick();
        check("midrst_before", int'(count), 6);
        reset_n = 1'b0;
        #1;
        check("midrst_count", int'(count), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_after_done", int'(done), 0);
            check("midrst_after_busy", int'(busy), 0);
        end

        // One-shot N=5
        load_value = 4'd5;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
            check("oneshot_count", int'(count), int'(seq[i]));
            check("oneshot_done", int'(done), (i == 5) ? 1 : 0);
            check("oneshot_busy", int'(busy), (i < 5) ? 1 : 0);
        end
        tick();
        check("oneshot_done_clear", int'(done), 0);

        // Pause: N=4, enable low on edges k+2..k+4
        load_value = 4'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_at = -1;
        for (int i = 1; i <= 12; i++) begin
            enable = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
            tick();
            if (i == 4) check("pause_frozen", int'(count), 3);
            if (done && done_at < 0) done_at = i;
            if (done_at >= 0) break;
        end
        enable = 1'b1;
        check("pause_done_at", done_at, 7);

        // Auto-reload N=3 for 12 enabled cycles
        auto_reload = 1'b1;
        load_value = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_mask = 12'd0;
        busy_all = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            done_mask[i] = done;
            if (!busy) busy_all = 1'b0;
        end
        check("reload_done_mask", int'(done_mask), 32'h924);
        check("reload_busy", int'(busy_all), 1);

        // Zero-length start
        load_value = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        check("zero_count", int'(count), 0);
        tick();
        check("zero_done_clear", int'(done), 0);
        auto_reload = 1'b0;

        // Priority: stop and start together at count 6
        load_value = 4'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("prio_at6", int'(count), 6);
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        check("prio_busy", int'(busy), 0);
        check("prio_count", int'(count), 0);
        check("prio_done", int'(done), 0);
        tick();
        check("prio_done_after", int'(done), 0);

        // Restart at count 1 with N=2
        load_value = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("restart_at1", int'(count), 1);
        load_value = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_count", int'(count), 2);
        check("restart_nodone", int'(done), 0);
        tick();
        check("restart_mid_done", int'(done), 0);
        tick();
        check("restart_done", int'(done), 1);

        // Max period N=15 with load_value changed mid-count
        load_value = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_value = 4'd3;
        done_at = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) check("max_count1", int'(count), 14);
            if (done && done_at < 0) done_at = i;
            if (done_at >= 0) break;
        end
        check("max_done_at", done_at, 15);
        check("max_busy_end", int'(busy), 0);

        // Stop in IDLE is harmless
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle_stop_busy", int'(busy), 0);
        check("idle_stop_done", int'(done), 0);
        tick();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
